// File: rtl/bd_emu_pkg.sv
`default_nettype none
// ============================================================================
// Package : bd_emu_pkg
// Brief   : Widths, response tag constant and FSM state type shared by the
//           BD-side loopback emulation blocks.
// Rev     : 1.0  initial release
// ============================================================================
package bd_emu_pkg;

    localparam int NDN    = 21;           // downstream word width (core -> BD)
    localparam int NUP    = 34;           // upstream word width (BD -> core)
    localparam int NTAGHI = NUP - NDN;    // width of the constant upper tag field

    localparam logic [NTAGHI-1:0] RESP_HI_DEFAULT = 13'h1000;

    // Responder sequencing; encoding pinned so waveforms read the same everywhere.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage : bd_emu_pkg
`default_nettype wire

// File: rtl/bd_loopback_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : bd_channel_if
// Brief     : Valid/ack word channel. A word moves on a rising edge where
//             v && a; the source holds d stable while v is high and a is low.
// Rev       : 1.0  initial release
// ============================================================================
interface bd_channel_if #(
    parameter int W = 21
) ();

    logic [W-1:0] d;
    logic         v;
    logic         a;

    modport master (output d, output v, input a);
    modport slave  (input d, input v, output a);

endinterface : bd_channel_if
`default_nettype wire

// File: rtl/bd_loopback_responder_fifo.sv
`default_nettype none
// ============================================================================
// Module : bd_loopback_responder_fifo
// Brief  : Show-ahead request queue. Head word is visible on o_rd_data while
//          not empty; full/empty/multi derive only from the stored level so
//          a pop never frees a slot for a push in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
module bd_loopback_responder_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 21
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_wr_en,
    input  wire logic [WIDTH-1:0] i_wr_data,
    input  wire logic             i_rd_en,
    output logic      [WIDTH-1:0] o_rd_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_multi
);

    localparam int          c_aw         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw:0] c_full_level = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw:0] c_one        = (c_aw + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_wr_en && !o_full;
    assign w_pop  = i_rd_en && !o_empty;

    // Storage array; contents need no reset because the level gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap on the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == c_full_level);
    assign o_multi   = (r_level > c_one);

endmodule : bd_loopback_responder_fifo
`default_nettype wire

// File: rtl/bd_loopback_responder.sv
`default_nettype none
// ============================================================================
// Module : bd_loopback_responder
// Brief  : BD-side link partner. Queues downstream words from the core and
//          answers each, in order, with {RESP_HI, word} after a per-word
//          programmable latency. Counts accepted and delivered words.
// Rev    : 1.0  initial release
// ============================================================================
module bd_loopback_responder
    import bd_emu_pkg::*;
#(
    parameter int                D       = 8,
    parameter int                NLAT    = 8,
    parameter logic [NTAGHI-1:0] RESP_HI = RESP_HI_DEFAULT
) (
    input  wire logic            clk,
    input  wire logic            reset,
    bd_channel_if.slave          from_core,
    bd_channel_if.master         to_core,
    input  wire logic            enable,
    input  wire logic [NLAT-1:0] lat,
    output logic      [15:0]     rx_count,
    output logic      [15:0]     tx_count
);

    localparam logic [NLAT-1:0] c_lat_one = NLAT'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NLAT-1:0]  r_cnt;
    logic [NLAT-1:0]  w_cnt_nxt;
    logic [15:0]      r_rx_count;
    logic [15:0]      r_tx_count;
    logic [NDN-1:0]   w_head;
    logic             w_empty;
    logic             w_full;
    logic             w_multi;
    logic             w_accept;
    logic             w_pop;
    logic             w_more;

    // Acceptance is held off during reset and while the queue is full.
    assign from_core.a = enable && !w_full && !reset;
    assign w_accept    = from_core.v && from_core.a;

    // A word will still be at the head after this pop: either one stays queued
    // or the core is delivering one on the same edge.
    assign w_more = w_multi || w_accept;

    bd_loopback_responder_fifo #(
        .DEPTH (D),
        .WIDTH (NDN)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_accept),
        .i_wr_data (from_core.d),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_multi   (w_multi)
    );

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: lat is captured once per word when it reaches the head.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_cnt_nxt   = lat;
                    w_state_nxt = (lat == '0) ? SEND : WAIT;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt <= c_lat_one) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (to_core.a) begin
                    w_pop = 1'b1;
                    if (w_more) begin
                        w_cnt_nxt   = lat;
                        w_state_nxt = (lat == '0) ? SEND : WAIT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign to_core.v = (r_state == SEND);
    assign to_core.d = (r_state == SEND) ? {RESP_HI, w_head} : '0;

    // Traffic counters; both wrap silently at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_count <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_accept) begin
                r_rx_count <= r_rx_count + 16'd1;
            end
            if (w_pop) begin
                r_tx_count <= r_tx_count + 16'd1;
            end
        end
    end

    assign rx_count = r_rx_count;
    assign tx_count = r_tx_count;

endmodule : bd_loopback_responder
`default_nettype wire

// File: tb/tb_bd_loopback_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_bd_loopback_responder
// Brief  : Self-checking bench for bd_loopback_responder: latency vectors,
//          full/enable/reset sequences, randomized traffic, counter wrap.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bd_loopback_responder;

    localparam logic [12:0] c_tag = 13'h1000;

    typedef struct {
        logic [7:0]  lat;
        logic [20:0] word;
        int          exp_delay;   // edges from accept edge until v is seen high
        logic [33:0] exp_d;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  lat = 8'd0;
    logic [15:0] rx_count;
    logic [15:0] tx_count;

    bd_channel_if #(.W(21)) from_core ();
    bd_channel_if #(.W(34)) to_core ();

    bd_loopback_responder #(
        .D    (8),
        .NLAT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .from_core (from_core),
        .to_core   (to_core),
        .enable    (enable),
        .lat       (lat),
        .rx_count  (rx_count),
        .tx_count  (tx_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [20:0] exp_q[$];
    logic [15:0] m_rx = 16'd0;
    logic [15:0] m_tx = 16'd0;
    logic        prev_hold = 1'b0;
    logic [33:0] prev_d = '0;
    vec_t        vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: every accepted word must come back once, in order,
    // tagged with c_tag; a stalled response must stay put.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_rx      = 16'd0;
            m_tx      = 16'd0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("resp_hold", {29'd0, to_core.v, to_core.d}, {29'd0, 1'b1, prev_d});
            end
            if (to_core.v && to_core.a) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected actual=%h required=none", to_core.d);
                end else begin
                    logic [20:0] w;
                    w = exp_q.pop_front();
                    chk("resp_data", {30'd0, to_core.d}, {30'd0, c_tag, w});
                end
                m_tx = m_tx + 16'd1;
            end
            prev_hold = to_core.v && !to_core.a;
            prev_d    = to_core.d;
            if (from_core.v && from_core.a) begin
                exp_q.push_back(from_core.d);
                m_rx = m_rx + 16'd1;
            end
        end
    end

    task automatic send_word(input logic [20:0] w);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        from_core.v = 1'b1;
        from_core.d = w;
        while (!got && n < 2000) begin
            @(negedge clk);
            got = from_core.a;
            @(posedge clk);
            #1;
            n++;
        end
        from_core.v = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout actual=no_accept required=accept word=%h", w);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || to_core.v) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain actual=pending%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic chk_counts(input string name);
        chk({name, "_rx"}, {48'd0, rx_count}, {48'd0, m_rx});
        chk({name, "_tx"}, {48'd0, tx_count}, {48'd0, m_tx});
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rx0;
        logic [15:0] tx0;
        logic        prod_done;
        int          n;

        vecs[0] = '{8'd0,   21'h0ABCD,  1,   34'h2_0000_ABCD};
        vecs[1] = '{8'd5,   21'h12345,  6,   34'h2_0001_2345};
        vecs[2] = '{8'd1,   21'h1FFFFF, 2,   34'h2_001F_FFFF};
        vecs[3] = '{8'd2,   21'h000000, 3,   34'h2_0000_0000};
        vecs[4] = '{8'd3,   21'h155555, 4,   34'h2_0015_5555};
        vecs[5] = '{8'd255, 21'h0F0F0,  256, 34'h2_0000_F0F0};
        vecs[6] = '{8'd7,   21'h100001, 8,   34'h2_0010_0001};

        from_core.v = 1'b0;
        from_core.d = '0;
        to_core.a   = 1'b0;

        // Reset state, with enable already high to show acceptance is still blocked.
        reset  = 1'b1;
        enable = 1'b1;
        cycles(3);
        chk("rst_v",  {63'd0, to_core.v}, 64'd0);
        chk("rst_d",  {30'd0, to_core.d}, 64'd0);
        chk("rst_a",  {63'd0, from_core.a}, 64'd0);
        chk("rst_rx", {48'd0, rx_count}, 64'd0);
        chk("rst_tx", {48'd0, tx_count}, 64'd0);
        reset = 1'b0;
        cycles(1);

        // Latency vectors into an empty queue with the sink always ready.
        to_core.a = 1'b1;
        for (int i = 0; i < 7; i++) begin
            lat = vecs[i].lat;
            send_word(vecs[i].word);
            n = 0;
            while (!to_core.v && n < 400) begin
                @(posedge clk);
                #1;
                n++;
                if (n == 1) lat = 8'($urandom_range(0, 255));
            end
            chk($sformatf("vec%0d_delay", i), 64'(n), 64'(vecs[i].exp_delay));
            chk($sformatf("vec%0d_d", i), {30'd0, to_core.d}, {30'd0, vecs[i].exp_d});
            cycles(1);
            chk($sformatf("vec%0d_v_low", i), {63'd0, to_core.v}, 64'd0);
            chk_counts($sformatf("vec%0d", i));
        end

        // Full queue: sink stalled, 10 words offered, only 8 fit.
        lat       = 8'd0;
        to_core.a = 1'b0;
        rx0 = rx_count;
        tx0 = tx_count;
        fork
            begin
                for (int i = 0; i < 10; i++) send_word(21'($urandom));
            end
            begin
                cycles(20);
                chk("full_rx8", {48'd0, rx_count}, {48'd0, rx0 + 16'd8});
                chk("full_a_low", {63'd0, from_core.a}, 64'd0);
                to_core.a = 1'b1;
                chk("full_a_same_cycle", {63'd0, from_core.a}, 64'd0);
                cycles(1);
                chk("full_a_after_pop", {63'd0, from_core.a}, 64'd1);
            end
        join
        drain("full");
        chk("full_rx10", {48'd0, rx_count}, {48'd0, rx0 + 16'd10});
        chk("full_tx10", {48'd0, tx_count}, {48'd0, tx0 + 16'd10});

        // Enable drop with three words queued: they drain, the fourth waits.
        lat       = 8'd2;
        to_core.a = 1'b0;
        rx0 = rx_count;
        tx0 = tx_count;
        for (int i = 0; i < 3; i++) send_word(21'($urandom));
        enable = 1'b0;
        fork
            send_word(21'h0C0DE);
            begin
                to_core.a = 1'b1;
                cycles(30);
                chk("en_tx3", {48'd0, tx_count}, {48'd0, tx0 + 16'd3});
                chk("en_rx3", {48'd0, rx_count}, {48'd0, rx0 + 16'd3});
                chk("en_a_low", {63'd0, from_core.a}, 64'd0);
                enable = 1'b1;
            end
        join
        drain("en");
        chk("en_rx4", {48'd0, rx_count}, {48'd0, rx0 + 16'd4});
        chk("en_tx4", {48'd0, tx_count}, {48'd0, tx0 + 16'd4});

        // Reset while a response is offered and stalled.
        lat       = 8'd0;
        to_core.a = 1'b0;
        send_word(21'h1ABCD);
        n = 0;
        while (!to_core.v && n < 50) begin
            cycles(1);
            n++;
        end
        chk("mid_v_high", {63'd0, to_core.v}, 64'd1);
        reset = 1'b1;
        cycles(1);
        chk("mid_v_low", {63'd0, to_core.v}, 64'd0);
        chk("mid_d_zero", {30'd0, to_core.d}, 64'd0);
        chk("mid_rx0", {48'd0, rx_count}, 64'd0);
        chk("mid_tx0", {48'd0, tx_count}, 64'd0);
        reset = 1'b0;
        cycles(1);
        to_core.a = 1'b1;
        for (int i = 0; i < 4; i++) send_word(21'($urandom));
        drain("mid");
        chk("mid_rx4", {48'd0, rx_count}, 64'd4);
        chk("mid_tx4", {48'd0, tx_count}, 64'd4);

        // Randomized traffic: stalls on both sides, lat 0..3, enable glitches.
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    cycles($urandom_range(0, 2));
                    send_word(21'($urandom));
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    to_core.a = 1'($urandom_range(0, 1));
                    lat       = 8'($urandom_range(0, 3));
                    enable    = ($urandom_range(0, 9) != 0);
                    cycles(1);
                end
            end
        join
        to_core.a = 1'b1;
        enable    = 1'b1;
        drain("rand");
        chk_counts("rand");

        // Counter wrap: 65537 words back to back after a fresh reset.
        reset = 1'b1;
        cycles(2);
        reset     = 1'b0;
        lat       = 8'd0;
        to_core.a = 1'b1;
        enable    = 1'b1;
        cycles(1);
        for (int i = 0; i < 65537; i++) send_word(21'(i));
        drain("wrap");
        chk("wrap_rx1", {48'd0, rx_count}, 64'd1);
        chk("wrap_tx1", {48'd0, tx_count}, 64'd1);
        chk_counts("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bd_loopback_responder
`default_nettype wire
